// File: rtl/vip_cfg_responder.sv
// Write-only Avalon-MM responder that terminates the VIP config bus:
// shadow/active register pairs per unit plus a serial coefficient-RAM stream.
module vip_cfg_responder #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [11:0] vid_w,
  output logic [11:0] vid_h,
  output logic [11:0] vid_hfp,
  output logic [11:0] vid_hs,
  output logic [11:0] vid_hb,
  output logic [11:0] vid_vfp,
  output logic [11:0] vid_vs,
  output logic [11:0] vid_vb,
  output logic        vid_interlaced,
  output logic        vid_go,
  output logic        mix_go,
  output logic        scl_go,
  output logic [11:0] mix_w,
  output logic [11:0] mix_h,
  output logic [11:0] mix_x,
  output logic [11:0] mix_y,
  output logic        mix_en,
  output logic [11:0] scl_w,
  output logic [11:0] scl_h,
  output logic        coef_wr,
  output logic [6:0]  coef_addr,
  output logic [8:0]  coef_data,
  output logic        bad_addr
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_EMIT} state_t;

  localparam logic [3:0] WAIT_L  = 4'(WAIT_CYCLES);
  localparam logic [3:0] WAIT_M4 = 4'((WAIT_CYCLES > 4) ? (WAIT_CYCLES - 4) : 0);

  state_t state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [1:0] tap_q, tap_d;
  logic emit_bank_q, emit_bank_d;
  logic [3:0] emit_phase_q, emit_phase_d;
  logic waitrequest_q, waitrequest_d;

  // video: index 0..7 = w, h, hfp, hs, hb, vfp, vs, vb
  logic [7:0][11:0] vsh_q, vsh_d, vact_q, vact_d;
  logic vint_sh_q, vint_sh_d, vint_act_q, vint_act_d;
  logic vbank_q, vbank_d, vvalid_q, vvalid_d;
  // mixer: index 0..3 = w, h, x, y
  logic [3:0][11:0] msh_q, msh_d, mact_q, mact_d;
  logic men_sh_q, men_sh_d, men_act_q, men_act_d;
  // scaler: index 0..1 = w, h
  logic [1:0][11:0] ssh_q, ssh_d, sact_q, sact_d;
  logic [3:0][8:0] stage_q, stage_d;

  logic vid_go_q, vid_go_d, mix_go_q, mix_go_d, scl_go_q, scl_go_d;
  logic coef_wr_q, coef_wr_d;
  logic [6:0] coef_addr_q, coef_addr_d;
  logic [8:0] coef_data_q, coef_data_d;
  logic bad_addr_q, bad_addr_d;

  logic accept, is_coef;
  logic [1:0] unit;
  logic [6:0] regn;
  logic [11:0] wd12;
  logic [1:0] tap_nx;
  logic unused_wdata;

  assign unit         = address[8:7];
  assign regn         = address[6:0];
  assign wd12         = writedata[11:0];
  assign accept       = write & ~waitrequest_q;
  assign is_coef      = (unit == 2'd0) && ((regn == 7'd12) || (regn == 7'd13));
  assign tap_nx       = tap_q + 2'd1;
  assign unused_wdata = ^writedata[31:12];

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    tap_d         = tap_q;
    emit_bank_d   = emit_bank_q;
    emit_phase_d  = emit_phase_q;
    waitrequest_d = 1'b1;
    vsh_d         = vsh_q;
    vact_d        = vact_q;
    vint_sh_d     = vint_sh_q;
    vint_act_d    = vint_act_q;
    vbank_d       = vbank_q;
    vvalid_d      = vvalid_q;
    msh_d         = msh_q;
    mact_d        = mact_q;
    men_sh_d      = men_sh_q;
    men_act_d     = men_act_q;
    ssh_d         = ssh_q;
    sact_d        = sact_q;
    stage_d       = stage_q;
    vid_go_d      = 1'b0;
    mix_go_d      = 1'b0;
    scl_go_d      = 1'b0;
    coef_wr_d     = 1'b0;
    coef_addr_d   = coef_addr_q;
    coef_data_d   = coef_data_q;
    bad_addr_d    = bad_addr_q;

    if (accept) begin
      case (unit)
        2'd0: begin
          case (regn)
            7'd0: if (writedata[0]) begin
              sact_d   = ssh_q;
              scl_go_d = 1'b1;
            end
            7'd3:  ssh_d[0] = wd12;
            7'd4:  ssh_d[1] = wd12;
            7'd12, 7'd13: begin
              emit_bank_d  = regn[0];
              emit_phase_d = writedata[3:0];
            end
            7'd14: stage_d[0] = writedata[8:0];
            7'd15: stage_d[1] = writedata[8:0];
            7'd16: stage_d[2] = writedata[8:0];
            7'd17: stage_d[3] = writedata[8:0];
            default: bad_addr_d = 1'b1;
          endcase
        end
        2'd1: begin
          case (regn)
            7'd0: if (writedata[0]) begin
              mact_d    = msh_q;
              men_act_d = men_sh_q;
              mix_go_d  = 1'b1;
            end
            7'd3:  msh_d[0] = wd12;
            7'd4:  msh_d[1] = wd12;
            7'd8:  msh_d[2] = wd12;
            7'd9:  msh_d[3] = wd12;
            7'd10: men_sh_d = writedata[0];
            default: bad_addr_d = 1'b1;
          endcase
        end
        2'd2: begin
          case (regn)
            7'd0: if (writedata[0] && vvalid_q) begin
              vact_d     = vsh_q;
              vint_act_d = vint_sh_q;
              vid_go_d   = 1'b1;
            end
            7'd4:  vbank_d  = writedata[0];
            7'd30: vvalid_d = writedata[0];
            // any nonzero bank silently swallows the whole 5..14 window
            7'd5:  if (!vbank_q) vint_sh_d = writedata[0];
            7'd6:  if (!vbank_q) vsh_d[0] = wd12;
            7'd7:  if (!vbank_q) vsh_d[1] = wd12;
            7'd8:  if (!vbank_q) bad_addr_d = 1'b1;
            7'd9:  if (!vbank_q) vsh_d[2] = wd12;
            7'd10: if (!vbank_q) vsh_d[3] = wd12;
            7'd11: if (!vbank_q) vsh_d[4] = wd12;
            7'd12: if (!vbank_q) vsh_d[5] = wd12;
            7'd13: if (!vbank_q) vsh_d[6] = wd12;
            7'd14: if (!vbank_q) vsh_d[7] = wd12;
            default: bad_addr_d = 1'b1;
          endcase
        end
        default: bad_addr_d = 1'b1;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        waitrequest_d = 1'b0;
        if (accept) begin
          if (is_coef) begin
            state_d       = S_EMIT;
            tap_d         = 2'd0;
            waitrequest_d = 1'b1;
            coef_wr_d     = 1'b1;
            coef_addr_d   = {regn[0], writedata[3:0], 2'd0};
            coef_data_d   = stage_q[0];
          end else if (WAIT_L != 4'd0) begin
            state_d       = S_BUSY;
            count_d       = WAIT_L;
            waitrequest_d = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (count_q <= 4'd1) begin
          state_d       = S_IDLE;
          waitrequest_d = 1'b0;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      S_EMIT: begin
        if (tap_q == 2'd3) begin
          if (WAIT_M4 != 4'd0) begin
            state_d = S_BUSY;
            count_d = WAIT_M4;
          end else begin
            state_d       = S_IDLE;
            waitrequest_d = 1'b0;
          end
        end else begin
          tap_d       = tap_nx;
          coef_wr_d   = 1'b1;
          coef_addr_d = {emit_bank_q, emit_phase_q, tap_nx};
          coef_data_d = stage_q[tap_nx];
        end
      end
      default: begin
        state_d       = S_IDLE;
        waitrequest_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      tap_q         <= '0;
      emit_bank_q   <= 1'b0;
      emit_phase_q  <= '0;
      waitrequest_q <= 1'b1;
      vsh_q         <= '0;
      vact_q        <= '0;
      vint_sh_q     <= 1'b0;
      vint_act_q    <= 1'b0;
      vbank_q       <= 1'b0;
      vvalid_q      <= 1'b0;
      msh_q         <= '0;
      mact_q        <= '0;
      men_sh_q      <= 1'b0;
      men_act_q     <= 1'b0;
      ssh_q         <= '0;
      sact_q        <= '0;
      stage_q       <= '0;
      vid_go_q      <= 1'b0;
      mix_go_q      <= 1'b0;
      scl_go_q      <= 1'b0;
      coef_wr_q     <= 1'b0;
      coef_addr_q   <= '0;
      coef_data_q   <= '0;
      bad_addr_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      tap_q         <= tap_d;
      emit_bank_q   <= emit_bank_d;
      emit_phase_q  <= emit_phase_d;
      waitrequest_q <= waitrequest_d;
      vsh_q         <= vsh_d;
      vact_q        <= vact_d;
      vint_sh_q     <= vint_sh_d;
      vint_act_q    <= vint_act_d;
      vbank_q       <= vbank_d;
      vvalid_q      <= vvalid_d;
      msh_q         <= msh_d;
      mact_q        <= mact_d;
      men_sh_q      <= men_sh_d;
      men_act_q     <= men_act_d;
      ssh_q         <= ssh_d;
      sact_q        <= sact_d;
      stage_q       <= stage_d;
      vid_go_q      <= vid_go_d;
      mix_go_q      <= mix_go_d;
      scl_go_q      <= scl_go_d;
      coef_wr_q     <= coef_wr_d;
      coef_addr_q   <= coef_addr_d;
      coef_data_q   <= coef_data_d;
      bad_addr_q    <= bad_addr_d;
    end
  end

  assign waitrequest    = waitrequest_q;
  assign vid_w          = vact_q[0];
  assign vid_h          = vact_q[1];
  assign vid_hfp        = vact_q[2];
  assign vid_hs         = vact_q[3];
  assign vid_hb         = vact_q[4];
  assign vid_vfp        = vact_q[5];
  assign vid_vs         = vact_q[6];
  assign vid_vb         = vact_q[7];
  assign vid_interlaced = vint_act_q;
  assign vid_go         = vid_go_q;
  assign mix_go         = mix_go_q;
  assign scl_go         = scl_go_q;
  assign mix_w          = mact_q[0];
  assign mix_h          = mact_q[1];
  assign mix_x          = mact_q[2];
  assign mix_y          = mact_q[3];
  assign mix_en         = men_act_q;
  assign scl_w          = sact_q[0];
  assign scl_h          = sact_q[1];
  assign coef_wr        = coef_wr_q;
  assign coef_addr      = coef_addr_q;
  assign coef_data      = coef_data_q;
  assign bad_addr       = bad_addr_q;

endmodule
